reg_to_axi_lite_master: RTL and testbench
=========================================

// Module: reg_to_axi_lite_master
// PURPOSE
// Register-interface to AXI4-Lite initiator bridge. It is the inverse of the AXI-Lite-to-reg slave path used by peripheral wrappers.
// It takes single reg_bus requests from a local master (debug/config unit) and issues them as AXI4-Lite transactions.
// One transaction is outstanding at a time. Request fields are latched on acceptance. AXI B/R responses map back to reg rdata/error.
// PARAMETERS
// ADDR_WIDTH      32      AXI-Lite and reg address width
// DATA_WIDTH      32      data width; STRB_WIDTH = DATA_WIDTH/8 (localparam); elaboration $error if DATA_WIDTH not 32 or 64
// AXI_PROT        3'b000  constant value driven on aw.prot and ar.prot
// reg_req_t       logic   reg_bus request struct (addr, write, wdata, wstrb, valid)
// reg_rsp_t       logic   reg_bus response struct (rdata, error, ready)
// axi_lite_req_t  logic   AXI-Lite request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready)
// axi_lite_rsp_t  logic   AXI-Lite response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid)
// PORTS
// clk_i           in   1        clock, all logic rising-edge
// rst_i           in   1        asynchronous active-high reset; one clock; reset is asynchronous and active-high
// reg_req_i       in   struct   reg_bus request from local master
// reg_rsp_o       out  struct   reg_bus response to local master
// axi_lite_req_o  out  struct   AXI-Lite master request channels
// axi_lite_rsp_i  in   struct   AXI-Lite master response channels
// BEHAVIOUR
// - FSM states: IDLE, WR (AW/W pending), WR_B, RD_AR, RD_R, RESP. Reset state is IDLE.
// - Reset values: all AXI valids/readies = 0; reg_rsp_o.ready = 0, .error = 0, .rdata = 0; latched addr/wdata/wstrb/flags = 0.
// - IDLE: when reg_req_i.valid is seen, latch addr/wdata/wstrb/write, clear aw_done/w_done. Next state is WR if write=1, else RD_AR.
// - IDLE: all AXI outputs idle; reg ready = 0.
// - WR: aw_valid = !aw_done and w_valid = !w_done; aw.addr/w.data/w.strb come from the latches. AW and W complete independently, in either order or the same cycle.
// - WR: each handshake sets its done flag and drops its valid the next cycle. When both are done (incl. same cycle), go to WR_B.
// - WR_B: b_ready = 1. On b_valid, latch error = b.resp[1] (SLVERR/DECERR = 1; OKAY/EXOKAY = 0) and rdata = 0; go to RESP.
// - RD_AR: ar_valid = 1 with latched addr; on ar_ready go to RD_R. RD_R: r_ready = 1; on r_valid latch rdata = r.data, error = r.resp[1]; go to RESP.
// - RESP: reg_rsp_o.ready = 1 for exactly one cycle, with latched rdata/error; then IDLE. rdata/error stay held until the next RESP.
// - Latency with zero-wait slave: request valid at T, AXI addr/data valid T+1, B/R accepted T+2, reg ready T+3.
// - Next request is accepted at the earliest at T+4.
// - reg_req_i is sampled only in IDLE. Changes while busy are ignored; the master must hold the request until ready (reg_bus rule).
// - AXI valids are held with stable payload until handshake, never withdrawn (AXI rule).
// - Address is passed through unaligned/unchanged. wstrb is ignored for reads. Write with wstrb = 0 is still issued.
// - rst_i mid-transaction: all outputs return to reset values asynchronously and the FSM goes to IDLE. The outstanding AXI transaction is dropped; the slave shares rst_i.
// - Late B/R after reset: a stray b_valid/r_valid arriving in IDLE is ignored (b_ready/r_ready = 0).
// TESTING
// - Write addr 0x1000_0010, wdata 0xDEADBEEF, strb 0xF, zero-wait slave, resp OKAY -> aw/w_valid at T+1, b_ready at T+2, ready at T+3, error = 0.
// - Same write, aw_ready delayed 3 cycles, w_ready immediate -> w_valid drops after 1 cycle, aw held stable 4 cycles, b_ready only after both done.
// - Read 0x0000_0040, slave returns rdata 0xCAFEF00D resp SLVERR -> ready 1 cycle, rdata = 0xCAFEF00D, error = 1.
// - Write with b.resp DECERR -> error = 1, rdata = 0. Then a read with resp OKAY -> error = 0 (error not sticky).
// - Back-to-back read then write, reg valid re-asserted right after ready -> second AXI transaction starts 1 cycle after IDLE re-entry; exactly one ready per request.
// - rst_i asserted in WR_B with bvalid pending -> all valids/ready 0 in same cycle. After release, FSM in IDLE, and a fresh read completes normally.

Source files
------------

// File: rtl/reg_to_axi_lite_master.sv
// Register-bus to AXI4-Lite initiator bridge: one outstanding transaction,
// request fields latched on acceptance, B/R responses mapped back to rdata/error.
module reg_to_axi_lite_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  AXI_PROT   = 3'b000,
  parameter type reg_req_t = struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    write;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    valid;
  },
  parameter type reg_rsp_t = struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  error;
    logic                  ready;
  },
  parameter type axi_lite_req_t = struct packed {
    struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [2:0]            prot;
    } aw;
    logic aw_valid;
    struct packed {
      logic [DATA_WIDTH-1:0]   data;
      logic [DATA_WIDTH/8-1:0] strb;
    } w;
    logic w_valid;
    logic b_ready;
    struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [2:0]            prot;
    } ar;
    logic ar_valid;
    logic r_ready;
  },
  parameter type axi_lite_rsp_t = struct packed {
    logic aw_ready;
    logic w_ready;
    struct packed {
      logic [1:0] resp;
    } b;
    logic b_valid;
    logic ar_ready;
    struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [1:0]            resp;
    } r;
    logic r_valid;
  }
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  reg_req_t      reg_req_i,
  output reg_rsp_t      reg_rsp_o,
  output axi_lite_req_t axi_lite_req_o,
  input  axi_lite_rsp_t axi_lite_rsp_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_width_check
    $error("reg_to_axi_lite_master: DATA_WIDTH must be 32 or 64");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_AR,
    RD_R,
    RESP
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    aw_valid_q;
  logic                    w_valid_q;
  logic                    b_ready_q;
  logic                    ar_valid_q;
  logic                    r_ready_q;
  logic                    ready_q;
  logic                    error_q;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    unused_resp_lsb;

  assign aw_hs = aw_valid_q & axi_lite_rsp_i.aw_ready;
  assign w_hs  = w_valid_q & axi_lite_rsp_i.w_ready;

  // Only resp[1] distinguishes error responses (SLVERR/DECERR).
  assign unused_resp_lsb = axi_lite_rsp_i.b.resp[0] ^ axi_lite_rsp_i.r.resp[0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (reg_req_i.valid) begin
            addr_q  <= reg_req_i.addr;
            wdata_q <= reg_req_i.wdata;
            wstrb_q <= reg_req_i.wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (reg_req_i.write) begin
              state      <= WR;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              state      <= RD_AR;
              ar_valid_q <= 1'b1;
            end
          end
        end
        WR: begin
          // AW and W retire independently; the combined test covers same-cycle completion.
          if (aw_hs) begin
            aw_done    <= 1'b1;
            aw_valid_q <= 1'b0;
          end
          if (w_hs) begin
            w_done    <= 1'b1;
            w_valid_q <= 1'b0;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state     <= WR_B;
            b_ready_q <= 1'b1;
          end
        end
        WR_B: begin
          if (axi_lite_rsp_i.b_valid) begin
            b_ready_q <= 1'b0;
            error_q   <= axi_lite_rsp_i.b.resp[1];
            rdata_q   <= '0;
            ready_q   <= 1'b1;
            state     <= RESP;
          end
        end
        RD_AR: begin
          if (axi_lite_rsp_i.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= RD_R;
          end
        end
        RD_R: begin
          if (axi_lite_rsp_i.r_valid) begin
            r_ready_q <= 1'b0;
            rdata_q   <= axi_lite_rsp_i.r.data;
            error_q   <= axi_lite_rsp_i.r.resp[1];
            ready_q   <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    axi_lite_req_o          = '0;
    axi_lite_req_o.aw.addr  = addr_q;
    axi_lite_req_o.aw.prot  = AXI_PROT;
    axi_lite_req_o.aw_valid = aw_valid_q;
    axi_lite_req_o.w.data   = wdata_q;
    axi_lite_req_o.w.strb   = wstrb_q;
    axi_lite_req_o.w_valid  = w_valid_q;
    axi_lite_req_o.b_ready  = b_ready_q;
    axi_lite_req_o.ar.addr  = addr_q;
    axi_lite_req_o.ar.prot  = AXI_PROT;
    axi_lite_req_o.ar_valid = ar_valid_q;
    axi_lite_req_o.r_ready  = r_ready_q;

    reg_rsp_o       = '0;
    reg_rsp_o.rdata = rdata_q;
    reg_rsp_o.error = error_q;
    reg_rsp_o.ready = ready_q;
  end

endmodule

// File: tb/tb_reg_to_axi_lite_master.sv
// Bench for reg_to_axi_lite_master: configurable AXI-Lite slave model,
// expected reg responses queued at request time and popped on each ready pulse.
module tb_reg_to_axi_lite_master;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ax_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_t;
  typedef struct packed {
    logic [1:0] resp;
  } b_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_t;
  typedef struct packed {
    ax_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ax_t  ar;
    logic ar_valid;
    logic r_ready;
  } axi_req_t;
  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    b_t   b;
    logic b_valid;
    logic ar_ready;
    r_t   r;
    logic r_valid;
  } axi_rsp_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } exp_t;

  logic     clk;
  logic     rst;
  reg_req_t req;
  reg_rsp_t rsp;
  axi_req_t axi_req;
  axi_rsp_t axi_rsp;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  logic tr_aw[64];
  logic tr_w[64];
  logic tr_b[64];
  logic tr_ar[64];
  logic tr_r[64];

  // slave model configuration and state
  int unsigned aw_delay, w_delay, b_delay;
  logic [1:0]  b_resp_cfg, r_resp_cfg;
  logic [31:0] r_data_cfg;
  logic        stray_b, stray_r;
  int unsigned aw_cnt, w_cnt, b_cnt;
  logic        got_aw, got_w, rd_pend, aw_wait, aw_unstable;
  logic [31:0] prev_aw_addr, cap_aw_addr, cap_w_data, cap_ar_addr;
  logic [3:0]  cap_w_strb;

  reg_to_axi_lite_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .AXI_PROT      (3'b000),
    .reg_req_t     (reg_req_t),
    .reg_rsp_t     (reg_rsp_t),
    .axi_lite_req_t(axi_req_t),
    .axi_lite_rsp_t(axi_rsp_t)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .reg_req_i     (req),
    .reg_rsp_o     (rsp),
    .axi_lite_req_o(axi_req),
    .axi_lite_rsp_i(axi_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always_comb begin
    axi_rsp          = '0;
    axi_rsp.aw_ready = axi_req.aw_valid && (aw_cnt >= aw_delay);
    axi_rsp.w_ready  = axi_req.w_valid && (w_cnt >= w_delay);
    axi_rsp.b_valid  = (got_aw && got_w && (b_cnt >= b_delay)) || stray_b;
    axi_rsp.b.resp   = b_resp_cfg;
    axi_rsp.ar_ready = axi_req.ar_valid;
    axi_rsp.r_valid  = rd_pend || stray_r;
    axi_rsp.r.data   = r_data_cfg;
    axi_rsp.r.resp   = r_resp_cfg;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt  <= 0;
      w_cnt   <= 0;
      b_cnt   <= 0;
      got_aw  <= 1'b0;
      got_w   <= 1'b0;
      rd_pend <= 1'b0;
      aw_wait <= 1'b0;
    end else begin
      if (axi_req.aw_valid) begin
        if (aw_wait && axi_req.aw.addr != prev_aw_addr) aw_unstable <= 1'b1;
        if (axi_rsp.aw_ready) begin
          got_aw      <= 1'b1;
          cap_aw_addr <= axi_req.aw.addr;
          aw_cnt      <= 0;
          aw_wait     <= 1'b0;
        end else begin
          aw_cnt       <= aw_cnt + 1;
          aw_wait      <= 1'b1;
          prev_aw_addr <= axi_req.aw.addr;
        end
      end
      if (axi_req.w_valid) begin
        if (axi_rsp.w_ready) begin
          got_w      <= 1'b1;
          cap_w_data <= axi_req.w.data;
          cap_w_strb <= axi_req.w.strb;
          w_cnt      <= 0;
        end else begin
          w_cnt <= w_cnt + 1;
        end
      end
      if (got_aw && got_w && !axi_rsp.b_valid) b_cnt <= b_cnt + 1;
      if (axi_rsp.b_valid && axi_req.b_ready) begin
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        b_cnt  <= 0;
      end
      if (axi_req.ar_valid && axi_rsp.ar_ready) begin
        rd_pend     <= 1'b1;
        cap_ar_addr <= axi_req.ar.addr;
      end
      if (axi_rsp.r_valid && axi_req.r_ready) rd_pend <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp.ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", rsp.ready, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp.rdata, e.rdata);
        check("rsp_error", rsp.error, e.error);
      end
    end
  end

  // Drives one request from the cycle after a rising edge; cycle 0 is the request cycle.
  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rdata,
                        input logic exp_err, output int lat);
    exp_t e;
    req.addr  = a;
    req.write = wr;
    req.wdata = d;
    req.wstrb = s;
    req.valid = 1'b1;
    e.rdata   = exp_rdata;
    e.error   = exp_err;
    sb.push_back(e);
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      tr_aw[c] = axi_req.aw_valid;
      tr_w[c]  = axi_req.w_valid;
      tr_b[c]  = axi_req.b_ready;
      tr_ar[c] = axi_req.ar_valid;
      tr_r[c]  = axi_req.r_ready;
      if (rsp.ready) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) check("ready_timeout", rsp.ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    req.valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=%0d", $time, 500000);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst         = 1'b1;
    req         = '0;
    aw_delay    = 0;
    w_delay     = 0;
    b_delay     = 0;
    b_resp_cfg  = 2'b00;
    r_resp_cfg  = 2'b00;
    r_data_cfg  = '0;
    stray_b     = 1'b0;
    stray_r     = 1'b0;
    aw_unstable = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_aw_valid", axi_req.aw_valid, 1'b0);
    check("rst_w_valid", axi_req.w_valid, 1'b0);
    check("rst_b_ready", axi_req.b_ready, 1'b0);
    check("rst_ar_valid", axi_req.ar_valid, 1'b0);
    check("rst_r_ready", axi_req.r_ready, 1'b0);
    check("rst_ready", rsp.ready, 1'b0);
    check("rst_rdata", rsp.rdata, 32'h0);
    check("rst_error", rsp.error, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(2);

    // zero-wait write, OKAY
    do_txn(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, lat);
    check("wr_latency", lat, 3);
    check("wr_aw_t0", tr_aw[0], 1'b0);
    check("wr_aw_t1", tr_aw[1], 1'b1);
    check("wr_w_t1", tr_w[1], 1'b1);
    check("wr_aw_t2", tr_aw[2], 1'b0);
    check("wr_b_t1", tr_b[1], 1'b0);
    check("wr_b_t2", tr_b[2], 1'b1);
    check("wr_aw_addr", cap_aw_addr, 32'h1000_0010);
    check("wr_w_data", cap_w_data, 32'hDEAD_BEEF);
    check("wr_w_strb", cap_w_strb, 4'hF);
    idle_cycles(2);

    // aw_ready held off three cycles, w immediate
    aw_delay = 3;
    do_txn(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, lat);
    aw_delay = 0;
    check("awd_latency", lat, 6);
    check("awd_w_t1", tr_w[1], 1'b1);
    check("awd_w_t2", tr_w[2], 1'b0);
    check("awd_aw_t1", tr_aw[1], 1'b1);
    check("awd_aw_t4", tr_aw[4], 1'b1);
    check("awd_aw_t5", tr_aw[5], 1'b0);
    check("awd_b_t4", tr_b[4], 1'b0);
    check("awd_b_t5", tr_b[5], 1'b1);
    check("awd_aw_stable", aw_unstable, 1'b0);
    check("awd_aw_addr", cap_aw_addr, 32'h1000_0010);
    idle_cycles(2);

    // read with SLVERR
    r_data_cfg = 32'hCAFE_F00D;
    r_resp_cfg = 2'b10;
    do_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b1, lat);
    check("rd_latency", lat, 3);
    check("rd_ar_t1", tr_ar[1], 1'b1);
    check("rd_r_t2", tr_r[2], 1'b1);
    check("rd_aw_t1", tr_aw[1], 1'b0);
    check("rd_ar_addr", cap_ar_addr, 32'h0000_0040);
    idle_cycles(2);

    // DECERR write, then OKAY read clears error; wstrb = 0 still issued
    b_resp_cfg = 2'b11;
    do_txn(1'b1, 32'h2000_0003, 32'h1234_5678, 4'h0, 32'h0, 1'b1, lat);
    b_resp_cfg = 2'b00;
    check("dec_w_strb", cap_w_strb, 4'h0);
    check("dec_aw_addr", cap_aw_addr, 32'h2000_0003);
    idle_cycles(2);
    @(negedge clk);
    check("dec_error_held", rsp.error, 1'b1);
    check("dec_rdata_held", rsp.rdata, 32'h0);
    @(posedge clk);
    #1;
    r_data_cfg = 32'h0BAD_F00D;
    r_resp_cfg = 2'b00;
    do_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, lat);
    idle_cycles(2);
    @(negedge clk);
    check("rd_rdata_held", rsp.rdata, 32'h0BAD_F00D);
    @(posedge clk);
    #1;

    // back-to-back read then write, valid kept high across the boundary
    r_data_cfg = 32'h5555_AAAA;
    do_txn(1'b0, 32'h0000_0080, 32'h0, 4'hF, 32'h5555_AAAA, 1'b0, lat);
    check("b2b_rd_latency", lat, 3);
    do_txn(1'b1, 32'h0000_0084, 32'h7777_8888, 4'h3, 32'h0, 1'b0, lat);
    check("b2b_wr_latency", lat, 3);
    check("b2b_wr_aw_t0", tr_aw[0], 1'b0);
    check("b2b_wr_aw_t1", tr_aw[1], 1'b1);
    check("b2b_wr_w_data", cap_w_data, 32'h7777_8888);
    idle_cycles(3);
    check("b2b_sb_empty", sb.size(), 0);

    // reset while waiting in WR_B for a B response
    b_delay   = 1000;
    req.addr  = 32'h3000_0000;
    req.write = 1'b1;
    req.wdata = 32'hFFFF_0000;
    req.wstrb = 4'hF;
    req.valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rstb_b_ready_before", axi_req.b_ready, 1'b1);
    #1;
    rst       = 1'b1;
    req.valid = 1'b0;
    #1;
    check("rstb_b_ready", axi_req.b_ready, 1'b0);
    check("rstb_aw_valid", axi_req.aw_valid, 1'b0);
    check("rstb_w_valid", axi_req.w_valid, 1'b0);
    check("rstb_ar_valid", axi_req.ar_valid, 1'b0);
    check("rstb_ready", rsp.ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    b_delay = 0;
    stray_b = 1'b1;
    stray_r = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stray_b_ready", axi_req.b_ready, 1'b0);
      check("stray_r_ready", axi_req.r_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    stray_b = 1'b0;
    stray_r = 1'b0;
    r_data_cfg = 32'hA5A5_5A5A;
    do_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0, lat);
    check("post_rst_rd_latency", lat, 3);
    idle_cycles(3);
    check("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
